// File: rtl/code_cnt_reg.sv
// WIDTH-bit set/load register with an enabled wrap/saturate up/down counter.
// Optional shift mode (mode 11) is built only when CODE_CNT_SHIFT_EN is defined.
module code_cnt_reg #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned SET_VALUE   = 7,
  parameter bit          SAT         = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SET_V = SET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V = '1;
  localparam logic [WIDTH-1:0] MIN_V = '0;
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic [WIDTH-1:0] w_nxt;
  logic             w_tc_nxt;
  logic             w_up;
  logic             w_dn;
  logic             w_sh;
  logic             w_at_max;
  logic             w_at_min;

  assign w_up     = en & (mode == 2'b01);
  assign w_dn     = en & (mode == 2'b10);
  assign w_at_max = (r_out == MAX_V);
  assign w_at_min = (r_out == MIN_V);

`ifdef CODE_CNT_SHIFT_EN
  assign w_sh = en & (mode == 2'b11);
`else
  logic w_unused_ser;
  assign w_sh         = 1'b0;
  assign w_unused_ser = ser_in;
`endif

  always_comb begin
    w_nxt    = r_out;
    w_tc_nxt = 1'b0;
    priority case (1'b1)
      set:  w_nxt = SET_V;
      load: w_nxt = data;
      w_up: begin
        if (w_at_max) begin
          w_tc_nxt = 1'b1;
          w_nxt    = SAT ? MAX_V : MIN_V;
        end else begin
          w_nxt = r_out + ONE_V;
        end
      end
      w_dn: begin
        if (w_at_min) begin
          w_tc_nxt = 1'b1;
          w_nxt    = SAT ? MIN_V : MAX_V;
        end else begin
          w_nxt = r_out - ONE_V;
        end
      end
`ifdef CODE_CNT_SHIFT_EN
      // tc carries the bit that falls off the top
      w_sh: begin
        w_nxt    = {r_out[WIDTH-2:0], ser_in};
        w_tc_nxt = r_out[WIDTH-1];
      end
`endif
      default: begin
        w_nxt    = r_out;
        w_tc_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= RST_V;
      r_tc  <= 1'b0;
    end else begin
      r_out <= w_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign zero = (r_out == MIN_V);

endmodule

// File: tb/tb_code_cnt_reg.sv
// Bench for code_cnt_reg: wrap (u0) and saturate (u1) instances share inputs.
// Shift checks are built only when CODE_CNT_SHIFT_EN is defined.
module tb_code_cnt_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       set = 1'b0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       ser_in = 1'b0;
  logic [2:0] data = 3'b000;
  logic [2:0] out0, out1;
  logic       tc0, tc1, zero0, zero1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  code_cnt_reg #(.WIDTH(3), .RESET_VALUE(0), .SET_VALUE(7), .SAT(1'b0)) u0 (
    .clk(clk), .reset(reset), .set(set), .load(load), .en(en),
    .mode(mode), .ser_in(ser_in), .data(data),
    .out(out0), .tc(tc0), .zero(zero0)
  );

  code_cnt_reg #(.WIDTH(3), .RESET_VALUE(0), .SET_VALUE(7), .SAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .set(set), .load(load), .en(en),
    .mode(mode), .ser_in(ser_in), .data(data),
    .out(out1), .tc(tc1), .zero(zero1)
  );

  always @(posedge clk)
    if (reset)
      assert (!$isunknown({set, load, en}))
        else $error("control input unknown while out of reset");

  typedef struct {
    logic       s;
    logic       l;
    logic       e;
    logic [1:0] m;
    logic       si;
    logic [2:0] d;
    logic [2:0] o0;
    logic       t0;
    logic [2:0] o1;
    logic       t1;
  } vec_t;

  typedef struct {
    logic [2:0] o0;
    logic       t0;
    logic [2:0] o1;
    logic       t1;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t x);
    chk({nm, ".out0"}, {29'd0, out0}, {29'd0, x.o0});
    chk({nm, ".tc0"}, {31'd0, tc0}, {31'd0, x.t0});
    chk({nm, ".zero0"}, {31'd0, zero0}, {31'd0, (x.o0 == 3'd0)});
    chk({nm, ".out1"}, {29'd0, out1}, {29'd0, x.o1});
    chk({nm, ".tc1"}, {31'd0, tc1}, {31'd0, x.t1});
    chk({nm, ".zero1"}, {31'd0, zero1}, {31'd0, (x.o1 == 3'd0)});
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t x;
    @(negedge clk);
    set = v.s; load = v.l; en = v.e;
    mode = v.m; ser_in = v.si; data = v.d;
    x.o0 = v.o0; x.t0 = v.t0; x.o1 = v.o1; x.t1 = v.t1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", nm);
    end else begin
      x = sb.pop_front();
      chk_all(nm, x);
    end
  endtask

  task automatic idle_inputs();
    set = 1'b0; load = 1'b0; en = 1'b0;
    mode = 2'b00; ser_in = 1'b0; data = 3'd0;
  endtask

  vec_t tbl[17];
  exp_t z;

  initial begin
    //          s  l  e  m      si d     o0 t0 o1 t1
    tbl[0]  = '{1, 1, 0, 2'b00, 0, 3'd2, 3'd7, 0, 3'd7, 0};
    tbl[1]  = '{0, 1, 0, 2'b00, 0, 3'd2, 3'd2, 0, 3'd2, 0};
    tbl[2]  = '{0, 0, 0, 2'b00, 0, 3'd2, 3'd2, 0, 3'd2, 0};
    tbl[3]  = '{0, 1, 0, 2'b00, 0, 3'd6, 3'd6, 0, 3'd6, 0};
    tbl[4]  = '{0, 0, 1, 2'b01, 0, 3'd0, 3'd7, 0, 3'd7, 0};
    tbl[5]  = '{0, 0, 1, 2'b01, 0, 3'd0, 3'd0, 1, 3'd7, 1};
    tbl[6]  = '{0, 0, 1, 2'b01, 0, 3'd0, 3'd1, 0, 3'd7, 1};
    tbl[7]  = '{0, 1, 1, 2'b01, 0, 3'd1, 3'd1, 0, 3'd1, 0};
    tbl[8]  = '{0, 0, 1, 2'b10, 0, 3'd0, 3'd0, 0, 3'd0, 0};
    tbl[9]  = '{0, 0, 1, 2'b10, 0, 3'd0, 3'd7, 1, 3'd0, 1};
    tbl[10] = '{0, 0, 1, 2'b10, 0, 3'd0, 3'd6, 0, 3'd0, 1};
    tbl[11] = '{0, 1, 0, 2'b00, 0, 3'd3, 3'd3, 0, 3'd3, 0};
    tbl[12] = '{0, 0, 0, 2'b01, 0, 3'd0, 3'd3, 0, 3'd3, 0};
    tbl[13] = '{0, 0, 0, 2'b01, 0, 3'd0, 3'd3, 0, 3'd3, 0};
    tbl[14] = '{0, 0, 0, 2'b01, 0, 3'd0, 3'd3, 0, 3'd3, 0};
    tbl[15] = '{0, 0, 0, 2'b01, 0, 3'd0, 3'd3, 0, 3'd3, 0};
    tbl[16] = '{0, 0, 1, 2'b00, 0, 3'd0, 3'd3, 0, 3'd3, 0};

    z = '{3'd0, 1'b0, 3'd0, 1'b0};

    // reset held low from time zero for two cycles
    #1;
    chk_all("por", z);
    repeat (2) @(posedge clk);
    #1;
    chk_all("por_hold", z);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // async reset mid-count at out=5, no clock edge needed
    apply('{0, 1, 0, 2'b00, 0, 3'd4, 3'd4, 0, 3'd4, 0}, "ld4");
    apply('{0, 0, 1, 2'b01, 0, 3'd0, 3'd5, 0, 3'd5, 0}, "up5");
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", z);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_over_en", z);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    apply('{0, 0, 1, 2'b01, 0, 3'd0, 3'd1, 0, 3'd1, 0}, "rel_up");

    // reset clears a pending tc asynchronously
    apply('{0, 1, 0, 2'b00, 0, 3'd0, 3'd0, 0, 3'd0, 0}, "ld0");
    apply('{0, 0, 1, 2'b10, 0, 3'd0, 3'd7, 1, 3'd0, 1}, "dn_tc");
    #2;
    reset = 1'b0;
    #1;
    chk_all("rst_tc", z);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    apply('{0, 1, 0, 2'b00, 0, 3'd5, 3'd5, 0, 3'd5, 0}, "ld5");
`ifdef CODE_CNT_SHIFT_EN
    apply('{0, 0, 1, 2'b11, 0, 3'd0, 3'd2, 1, 3'd2, 1}, "sh0");
    apply('{0, 0, 1, 2'b11, 1, 3'd0, 3'd5, 0, 3'd5, 0}, "sh1");
    apply('{0, 0, 1, 2'b11, 1, 3'd0, 3'd3, 1, 3'd3, 1}, "sh2");
    apply('{1, 0, 1, 2'b11, 0, 3'd0, 3'd7, 0, 3'd7, 0}, "set_sh");
    apply('{0, 1, 1, 2'b11, 0, 3'd4, 3'd4, 0, 3'd4, 0}, "ld_sh");
`else
    apply('{0, 0, 1, 2'b11, 1, 3'd0, 3'd5, 0, 3'd5, 0}, "m11_a");
    apply('{0, 0, 1, 2'b11, 0, 3'd0, 3'd5, 0, 3'd5, 0}, "m11_b");
    apply('{0, 0, 1, 2'b11, 1, 3'd0, 3'd5, 0, 3'd5, 0}, "m11_c");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
